// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the instruction/data memory
//               arbiter: FSM state encoding, requester IDs, one-hot grant
//               codes and the byte-to-word address offset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_e;

    // Requester identity, also used as the round-robin history bit
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // Byte address bits below this offset select a byte inside a word
    localparam int unsigned C_WORD_OFFSET = 2;

    // One-hot grant encodings returned by the selector
    localparam logic [1:0] C_GRANT_NONE = 2'b00;
    localparam logic [1:0] C_GRANT_I    = 2'b01;
    localparam logic [1:0] C_GRANT_D    = 2'b10;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//==============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the core-side fetch/data handshakes and the RAM port
//               of the memory arbiter. The slave modport is the arbiter's
//               view; the master modport is the core-plus-RAM view.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int MEM_AW = 10
) ();

    // Instruction fetch port
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_ready;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    // Load/store data port
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_ready;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    // Single-port RAM
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : mem_arbiter_if

`default_nettype wire

// File: rtl/arb_select.sv
//==============================================================================
// Module      : arb_select
// Description : Grant selection between the instruction and data requesters.
//               Returns a one-hot grant. Default build: fixed priority, data
//               wins. With MEM_ARB_ROUND_ROBIN_EN defined, a one-bit
//               last_grant register (reset to instruction) makes a tie go to
//               the requester not granted most recently.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module arb_select
    import mem_arb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_req_i,
    input  wire logic       d_req_i,
    input  wire logic       accept_i,   // FSM can accept this cycle
    output logic      [1:0] grant_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    // Tie goes to whoever was not served last; single requests pass through
    always_comb begin
        grant_o = C_GRANT_NONE;
        if (i_req_i && d_req_i) begin
            grant_o = (last_grant_q == REQ_I) ? C_GRANT_D : C_GRANT_I;
        end else if (d_req_i) begin
            grant_o = C_GRANT_D;
        end else if (i_req_i) begin
            grant_o = C_GRANT_I;
        end
    end

    // History follows every accepted request, reads and writes alike
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i && (grant_o == C_GRANT_D)) begin
            last_grant_d = REQ_D;
        end else if (accept_i && (grant_o == C_GRANT_I)) begin
            last_grant_d = REQ_I;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`else

    // Fixed priority: data always beats instruction fetch
    always_comb begin
        grant_o = C_GRANT_NONE;
        if (d_req_i) begin
            grant_o = C_GRANT_D;
        end else if (i_req_i) begin
            grant_o = C_GRANT_I;
        end
    end

    // No history is kept in this build
    logic w_unused_sel;
    assign w_unused_sel = clk ^ reset ^ accept_i;

`endif

endmodule : arb_select

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous-read RAM between the
//               instruction-fetch and load/store ports of a core. At most
//               one read is outstanding; its response is steered back to the
//               requester that issued it. Writes complete in the accept cycle.
//               Optional macro: MEM_ARB_ROUND_ROBIN_EN (round-robin ties,
//               handled inside arb_select).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] w_grant;
    logic       w_idle;

    assign w_idle = (state_q == IDLE);

    arb_select u_arb_select (
        .clk      (clk),
        .reset    (reset),
        .i_req_i  (bus.i_req),
        .d_req_i  (bus.d_req),
        .accept_i (w_idle),
        .grant_o  (w_grant)
    );

    // State register; reset drops any outstanding read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, RAM command and ready handshakes
    always_comb begin
        state_d       = state_q;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = bus.d_wdata;
        case (state_q)
            IDLE: begin
                if (w_grant == C_GRANT_D) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.d_addr[C_WORD_OFFSET +: MEM_AW];
                    bus.d_ready  = 1'b1;
                    if (bus.d_we) begin
                        // Write commits on this edge; stay free for the next
                        bus.mem_we = bus.d_wstrb;
                    end else begin
                        state_d = D_WAIT;
                    end
                end else if (w_grant == C_GRANT_I) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.i_addr[C_WORD_OFFSET +: MEM_AW];
                    bus.i_ready  = 1'b1;
                    state_d      = I_WAIT;
                end
            end
            I_WAIT, D_WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is returned from registered state only
    assign bus.i_rvalid = (state_q == I_WAIT);
    assign bus.d_rvalid = (state_q == D_WAIT);
    assign bus.i_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

    // Byte-lane and above-RAM address bits do not take part in addressing
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.i_addr[31:MEM_AW+C_WORD_OFFSET],
                             bus.i_addr[C_WORD_OFFSET-1:0],
                             bus.d_addr[31:MEM_AW+C_WORD_OFFSET],
                             bus.d_addr[C_WORD_OFFSET-1:0]};

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a simple
//               synchronous-read RAM model. Honors MEM_ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int MEM_AW = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

    mem_arbiter #(.MEM_AW(MEM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read (read-before-write), byte-lane writes.
    logic [31:0] ram [0:(1<<MEM_AW)-1];
    logic [31:0] r_rdata;
    assign bus.mem_rdata = r_rdata;

    always @(posedge clk) begin
        if (reset) begin
            ram[1] <= 32'hA5A5_0001;
            ram[2] <= 32'h0000_0013;
            ram[4] <= 32'h1122_3344;
            ram[8] <= 32'h0BAD_0008;
        end else if (bus.mem_en) begin
            r_rdata <= ram[bus.mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_wstrb = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req_mem_en got %b exp 0", bus.mem_en);
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0008;
        #1;
        checks++;
        if ({bus.i_ready, bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 4'b0, 10'd2}) begin
            errors++;
            $display("FAIL fetch_accept got rdy=%b en=%b we=%b addr=%0d exp 1 1 0000 2", bus.i_ready, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata, bus.i_ready, bus.mem_en, bus.d_rvalid} !== {1'b1, 32'h0000_0013, 3'b000}) begin
            errors++;
            $display("FAIL fetch_rdata got rv=%b data=%h rdy=%b en=%b drv=%b exp 1 00000013 0 0 0", bus.i_rvalid, bus.i_rdata, bus.i_ready, bus.mem_en, bus.d_rvalid);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0010;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_wstrb = 4'b0011;
        #1;
        checks++;
        if ({bus.d_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 4'b0011, 10'd4, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_accept got rdy=%b en=%b we=%b addr=%0d wd=%h exp 1 1 0011 4 deadbeef", bus.d_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        bus.d_we = 1'b0;
        #1;
        checks++;
        if ({bus.d_ready, bus.d_rvalid, bus.mem_en, bus.mem_we} !== {1'b1, 1'b0, 1'b1, 4'b0}) begin
            errors++;
            $display("FAIL read_after_write_accept got rdy=%b rv=%b en=%b we=%b exp 1 0 1 0000", bus.d_ready, bus.d_rvalid, bus.mem_en, bus.mem_we);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata, bus.d_ready} !== {1'b1, 32'h1122_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL partial_write_readback got rv=%b data=%h rdy=%b exp 1 1122beef 0", bus.d_rvalid, bus.d_rdata, bus.d_ready);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0008;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0004;
        #1;
        checks++;
        if ({bus.d_ready, bus.i_ready, bus.mem_addr} !== {1'b1, 1'b0, 10'd1}) begin
            errors++;
            $display("FAIL prio_n got d_rdy=%b i_rdy=%b addr=%0d exp 1 0 1", bus.d_ready, bus.i_ready, bus.mem_addr);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata, bus.i_ready, bus.i_rvalid, bus.mem_en} !== {1'b1, 32'hA5A5_0001, 3'b000}) begin
            errors++;
            $display("FAIL prio_n1 got drv=%b data=%h i_rdy=%b irv=%b en=%b exp 1 a5a50001 0 0 0", bus.d_rvalid, bus.d_rdata, bus.i_ready, bus.i_rvalid, bus.mem_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.i_ready, bus.d_rvalid, bus.mem_addr} !== {1'b1, 1'b0, 10'd2}) begin
            errors++;
            $display("FAIL prio_n2 got i_rdy=%b drv=%b addr=%0d exp 1 0 2", bus.i_ready, bus.d_rvalid, bus.mem_addr);
        end
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata, bus.d_rvalid} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            errors++;
            $display("FAIL prio_n3 got irv=%b data=%h drv=%b exp 1 00000013 0", bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0030;
        bus.d_wdata = 32'h1234_5678;
        bus.d_wstrb = 4'b1111;
        #1;
        checks++;
        if ({bus.d_ready, bus.mem_we} !== {1'b1, 4'b1111}) begin
            errors++;
            $display("FAIL b2b_write0 got rdy=%b we=%b exp 1 1111", bus.d_ready, bus.mem_we);
        end
        @(negedge clk);
        bus.d_addr  = 32'h0000_0034;
        bus.d_wdata = 32'h9ABC_DEF0;
        #1;
        checks++;
        if ({bus.d_ready, bus.mem_we, bus.mem_addr} !== {1'b1, 4'b1111, 10'd13}) begin
            errors++;
            $display("FAIL b2b_write1 got rdy=%b we=%b addr=%0d exp 1 1111 13", bus.d_ready, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk);
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0030;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL b2b_readback0 got rv=%b data=%h exp 1 12345678", bus.d_rvalid, bus.d_rdata);
        end
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0034;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h9ABC_DEF0}) begin
            errors++;
            $display("FAIL b2b_readback1 got rv=%b data=%h exp 1 9abcdef0", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_drop();
        // Data write request shows up during a fetch's wait cycle and is
        // withdrawn before it is accepted: RAM must not be touched.
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0004;
        @(negedge clk);
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0020;
        bus.d_wdata = 32'hFFFF_FFFF;
        bus.d_wstrb = 4'b1111;
        #1;
        checks++;
        if ({bus.d_ready, bus.mem_en, bus.mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL wait_blocks_req got rdy=%b en=%b we=%b exp 0 0 0000", bus.d_ready, bus.mem_en, bus.mem_we);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0020;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h0BAD_0008}) begin
            errors++;
            $display("FAIL dropped_write_no_effect got rv=%b data=%h exp 1 0bad0008", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_1004;
        #1;
        checks++;
        if ({bus.d_ready, bus.mem_addr} !== {1'b1, 10'd1}) begin
            errors++;
            $display("FAIL addr_wrap got rdy=%b addr=%0d exp 1 1", bus.d_ready, bus.mem_addr);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL addr_wrap_data got rv=%b data=%h exp 1 a5a50001", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_arbitration_held();
        logic [3:0] got;
        logic [3:0] exp_seq;
        int         n;
        got = 4'b0;
        n   = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;   // slot0 D, slot1 I, slot2 D, slot3 I (bit=1 means D)
`else
        exp_seq = 4'b1111;
`endif
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset      = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0008;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0004;
        for (int k = 0; k < 8; k++) begin
            #1;
            if ((bus.d_ready || bus.i_ready) && n < 4) begin
                got[n] = bus.d_ready;
                n++;
            end
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL held_accept_count got %0d exp 4", n);
        end
        checks++;
        if (got !== exp_seq) begin
            errors++;
            $display("FAIL held_grant_seq got %b exp %b (bit k = slot k, 1 = D)", got, exp_seq);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0008;
        #1;
        checks++;
        if (bus.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_accept got %b exp 1", bus.d_ready);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        reset     = 1'b1;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_no_rvalid got %b exp 0", bus.d_rvalid);
        end
        @(negedge clk);
        reset      = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0004;
        #1;
        checks++;
        if ({bus.i_ready, bus.d_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_first_accept got i_rdy=%b drv=%b exp 1 0", bus.i_ready, bus.d_rvalid);
        end
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata, bus.d_rvalid} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin
            errors++;
            $display("FAIL rst_post_fetch got irv=%b data=%h drv=%b exp 1 a5a50001 0", bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch();
        test_write_read();
        test_priority();
        test_back_to_back();
        test_drop();
        test_wrap();
        test_arbitration_held();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port synchronous-read RAM between the processor's instruction-fetch port and its load/store data port. It sits between the core's memory interface and the unified program/data RAM. It serializes accesses with a valid/ready handshake and keeps at most one read outstanding. It routes each read response back to the requester that issued it.

## Interface
Parameters:
- `MEM_AW`, default 10: RAM word-address width; RAM depth is 2^MEM_AW 32-bit words.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `i_req`  in  1: instruction fetch request; held with `i_addr` until `i_ready`.
- `i_addr`  in  32: byte address of the fetch.
- `i_ready`  out  1: fetch accepted this cycle.
- `i_rvalid`  out  1: `i_rdata` valid.
- `i_rdata`  out  32: fetched word.
- `d_req`  in  1: data request; held with all `d_*` inputs until `d_ready`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_addr`  in  32: byte address.
- `d_wdata`  in  32: write data.
- `d_wstrb`  in  4: byte enables for writes.
- `d_ready`  out  1: data request accepted this cycle.
- `d_rvalid`  out  1: `d_rdata` valid (reads only).
- `d_rdata`  out  32: read word.
- `mem_en`  out  1: RAM access this cycle.
- `mem_we`  out  4: RAM byte write enables. Zero for reads.
- `mem_addr`  out  MEM_AW: word address, `addr[MEM_AW+1:2]`.
- `mem_wdata`  out  32: RAM write data.
- `mem_rdata`  in  32: RAM read data, valid the cycle after `mem_en` with `mem_we`==0.

## Operation
States: IDLE, I_WAIT, D_WAIT.

IDLE:
- Grant one pending request combinationally.
- Drive `mem_en`=1 with the granted address, and assert that requester's ready.
- Data read: go to D_WAIT.
- Instruction fetch (always a read): go to I_WAIT.
- Data write: `mem_we`=`d_wstrb`, `mem_wdata`=`d_wdata`, `d_ready`=1, remain in IDLE. No `d_rvalid` is issued for writes.

I_WAIT and D_WAIT:
- Assert the owner's rvalid and forward `mem_rdata` onto its rdata.
- Accept no new request and assert no ready.
- Return to IDLE.

Arbitration, both requesting in IDLE: fixed priority, data wins.

Addressing:
- Address bits [1:0] are ignored.
- Address bits above MEM_AW+1 are ignored, so addresses wrap modulo the RAM size.

Output defaults:
- ready and rvalid signals are 0 except as stated above.
- `mem_we`=0 whenever `mem_en`=0.
- rdata outputs carry `mem_rdata` unconditionally; they are meaningful only when the matching rvalid is asserted.

Boundary conditions:
- No request pending in IDLE: `mem_en`=0.
- `d_req` dropped before `d_ready` (protocol violation): no access is made and no state change occurs.
- Reset asserted while in I_WAIT or D_WAIT: the outstanding read is discarded and no rvalid is issued after reset.

## Timing
- Reset values: state=IDLE. All ready and rvalid outputs 0, `mem_en`=0, `mem_we`=0.
- Read latency: accept on cycle N, rvalid on cycle N+1. Read throughput is one per 2 cycles.
- Write: accepted and committed on the same edge. Write throughput is one per cycle.
- ready is a combinational function of state and the req inputs. rvalid depends only on registered state.
- A requester held off by the other side waits in IDLE with its request asserted.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, the requester not granted last wins.
  - A one-bit `last_grant` register records the most recent grant, updated on every accepted request.
  - `last_grant` resets to instruction, so data wins the first tie.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed data-over-instruction priority, and no `last_grant` register exists.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, I_WAIT, D_WAIT);
  - the requester-ID enum (REQ_I, REQ_D);
  - the word-offset constant (2).
- Sub-module `arb_select` contains the grant logic. It takes both requests and `last_grant` and returns a one-hot grant. It holds the only `MEM_ARB_ROUND_ROBIN_EN` conditional.
- The top level holds the FSM and the muxing.

## Test plan
- Fetch only, `i_addr`=0x0000_0008, RAM word 2 = 0x0000_0013 → `i_ready` on cycle N, `i_rvalid`=1 with `i_rdata`=0x0000_0013 on N+1, `mem_addr`=2.
- Write `d_addr`=0x10, `d_wdata`=0xDEADBEEF, `d_wstrb`=4'b0011, then read 0x10 → `d_ready` on the write cycle with `mem_we`=4'b0011. The read returns 0x????BEEF, with the upper bytes holding the previous contents.
- `i_req` and `d_req` (read) asserted together with fixed priority → `d_ready` on cycle N and `d_rvalid` on N+1; `i_ready` on N+2 and `i_rvalid` on N+3.
- With `MEM_ARB_ROUND_ROBIN_EN`, both requesters held continuously → grants alternate D, I, D, I. Without the macro → D is granted every accept slot.
- Address wrap with MEM_AW=10: read 0x0000_1004 → `mem_addr`=1.
- Reset asserted in D_WAIT → no `d_rvalid` afterwards. State returns to IDLE, and the next request is accepted on the first cycle after reset deasserts.
